// File: rtl/fetch_stage.sv
// Instruction fetch stage: drives a single-outstanding-request instruction
// memory port and feeds the IF/ID pipeline register. A one-entry skid buffer
// absorbs a response that lands while decode is stalled, and a DROP state
// swallows the stale response of a request overtaken by a redirect.
module fetch_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stallD,
   input  logic        flushD,
   input  logic        pcSrcE,
   input  logic [31:0] pcTargetE,
   output logic        imemReq,
   output logic [31:0] imemAddr,
   input  logic        imemAck,
   input  logic [31:0] imemRdata,
   output logic [31:0] instrD,
   output logic [31:0] pcD,
   output logic [31:0] pcPlus4D,
   output logic        validD
);

   typedef enum logic [1:0] {REQ, HOLD, DROP} state_t;

   state_t      state;
   logic [31:0] pc_f;
   logic [31:0] drop_addr;
   logic [31:0] skid_instr;
   logic [31:0] pc_plus4;
   logic [31:0] target;
   logic        ack;
   logic        take_resp;
   logic        take_skid;
   logic        to_hold;
   logic        stay_hold;
   logic        to_drop;

   assign pc_plus4 = pc_f + 32'd4;
   assign target   = pcTargetE & 32'hFFFF_FFFC;
   // While a stale request drains, the bus must keep showing its address
   assign imemAddr = (state == DROP) ? drop_addr : pc_f;

   // Decode this cycle's fetch decision from state, handshake and pipeline controls
   always_comb begin
      ack       = imemReq & imemAck;
      take_resp = (state == REQ)  && ack && !pcSrcE && !flushD && !stallD;
      take_skid = (state == HOLD) && !pcSrcE && !flushD && !stallD;
      to_hold   = (state == REQ)  && ack && stallD && !flushD && !pcSrcE;
      stay_hold = (state == HOLD) && stallD && !flushD && !pcSrcE;
      // Only a genuinely outstanding request needs draining after a redirect
      to_drop   = (state == REQ)  && pcSrcE && imemReq && !imemAck;
   end

   // FSM state, fetch PC and the registered request flag
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= REQ;
         pc_f    <= RESET_PC;
         imemReq <= 1'b0;
      end else begin
         // No new request while a buffered instruction waits for decode
         imemReq <= !(to_hold || stay_hold);
         if (pcSrcE)
            pc_f <= target;
         else if (take_resp || take_skid)
            pc_f <= pc_plus4;
         case (state)
            REQ: begin
               if (to_drop)
                  state <= DROP;
               else if (to_hold)
                  state <= HOLD;
            end
            HOLD: begin
               if (!stay_hold)
                  state <= REQ;
            end
            DROP: begin
               if (imemAck)
                  state <= REQ;
            end
            default: state <= REQ;
         endcase
      end
   end

   // IF/ID register: flush inserts a bubble, stall holds, otherwise advance
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         instrD   <= NOP_INSTR;
         pcD      <= 32'd0;
         pcPlus4D <= 32'd0;
         validD   <= 1'b0;
      end else if (flushD) begin
         instrD <= NOP_INSTR;
         validD <= 1'b0;
      end else if (!stallD) begin
         if (take_resp) begin
            instrD   <= imemRdata;
            pcD      <= pc_f;
            pcPlus4D <= pc_plus4;
            validD   <= 1'b1;
         end else if (take_skid) begin
            instrD   <= skid_instr;
            pcD      <= pc_f;
            pcPlus4D <= pc_plus4;
            validD   <= 1'b1;
         end else begin
            instrD <= NOP_INSTR;
            validD <= 1'b0;
         end
      end
   end

   // Skid word and drained-request address are qualified by state, so no reset
   always_ff @(posedge clk) begin
      if (to_hold)
         skid_instr <= imemRdata;
      if (to_drop)
         drop_addr <= pc_f;
   end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios followed by randomized pipeline
// control and memory latency, compared every cycle with a transaction-level
// model of the fetch stage.
module tb_fetch_stage;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk;
   logic        reset;
   logic        stallD;
   logic        flushD;
   logic        pcSrcE;
   logic [31:0] pcTargetE;
   logic        imemReq;
   logic [31:0] imemAddr;
   logic        imemAck;
   logic [31:0] imemRdata;
   logic [31:0] instrD;
   logic [31:0] pcD;
   logic [31:0] pcPlus4D;
   logic        validD;

   int n_tests;
   int n_fail;

   // memory environment
   int lat_mode;
   int mem_left;
   bit mem_busy;

   // reference model of the fetch stage
   logic [31:0] m_pc;
   logic [31:0] m_buf;
   logic [31:0] m_old;
   bit          m_buffered;
   bit          m_draining;
   bit          m_live;
   logic        exp_req;
   logic [31:0] exp_addr;
   logic [31:0] e_instr;
   logic [31:0] e_pc;
   logic [31:0] e_pc4;
   logic        e_valid;

   fetch_stage dut (
      .clk       (clk),
      .reset     (reset),
      .stallD    (stallD),
      .flushD    (flushD),
      .pcSrcE    (pcSrcE),
      .pcTargetE (pcTargetE),
      .imemReq   (imemReq),
      .imemAddr  (imemAddr),
      .imemAck   (imemAck),
      .imemRdata (imemRdata),
      .instrD    (instrD),
      .pcD       (pcD),
      .pcPlus4D  (pcPlus4D),
      .validD    (validD)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [31:0] memf(input logic [31:0] a);
      return a ^ 32'hC0DE_0000;
   endfunction

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check1(input string name, input logic act, input logic exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_pc       = 32'h0;
      m_buffered = 0;
      m_draining = 0;
      m_live     = 0;
      e_instr    = NOP;
      e_pc       = 32'h0;
      e_pc4      = 32'h0;
      e_valid    = 1'b0;
      exp_req    = 1'b0;
      exp_addr   = m_pc;
   endtask

   task automatic model_bubble();
      e_instr = NOP;
      e_valid = 1'b0;
   endtask

   // One clock of the fetch stage, described in terms of what happens to the
   // fetched word (delivered, parked, discarded) and where fetching goes next.
   task automatic model_step();
      logic        got;
      logic [31:0] tgt;
      if (reset) begin
         model_reset();
         return;
      end
      tgt = pcTargetE & 32'hFFFF_FFFC;
      got = exp_req && imemAck;
      if (flushD)
         model_bubble();
      else if (!stallD) begin
         if (m_buffered && !pcSrcE) begin
            e_instr = m_buf; e_pc = m_pc; e_pc4 = m_pc + 32'd4; e_valid = 1'b1;
         end else if (!m_buffered && !m_draining && got && !pcSrcE) begin
            e_instr = imemRdata; e_pc = m_pc; e_pc4 = m_pc + 32'd4; e_valid = 1'b1;
         end else
            model_bubble();
      end
      if (m_buffered) begin
         if (pcSrcE) begin
            m_pc = tgt; m_buffered = 0;
         end else if (flushD)
            m_buffered = 0;
         else if (!stallD) begin
            m_pc = m_pc + 32'd4; m_buffered = 0;
         end
      end else if (m_draining) begin
         if (pcSrcE) m_pc = tgt;
         if (imemAck) m_draining = 0;
      end else if (pcSrcE) begin
         if (exp_req && !imemAck) begin
            m_old = m_pc; m_draining = 1;
         end
         m_pc = tgt;
      end else if (got && !flushD) begin
         if (stallD) begin
            m_buf = imemRdata; m_buffered = 1;
         end else
            m_pc = m_pc + 32'd4;
      end
      m_live   = 1;
      exp_req  = m_live && !m_buffered;
      exp_addr = m_draining ? m_old : m_pc;
   endtask

   task automatic compare();
      check1("imemReq", imemReq, exp_req);
      if (exp_req) check32("imemAddr", imemAddr, exp_addr);
      check32("instrD", instrD, e_instr);
      check32("pcD", pcD, e_pc);
      check32("pcPlus4D", pcPlus4D, e_pc4);
      check1("validD", validD, e_valid);
   endtask

   // Memory reacts to the request the DUT shows; latency fixed or random
   task automatic drive_mem();
      if (reset) begin
         imemAck   = 1'($urandom_range(0, 1));
         imemRdata = $urandom;
         mem_busy  = 0;
      end else if (!imemReq) begin
         imemAck   = 1'b0;
         imemRdata = $urandom;
         mem_busy  = 0;
      end else begin
         if (!mem_busy) begin
            mem_busy = 1;
            mem_left = (lat_mode < 0) ? int'($urandom_range(0, 3)) : lat_mode;
         end
         if (mem_left == 0) begin
            imemAck   = 1'b1;
            imemRdata = memf(imemAddr);
            mem_busy  = 0;
         end else begin
            imemAck   = 1'b0;
            imemRdata = $urandom;
            mem_left--;
         end
      end
   endtask

   task automatic cycle(input bit st, input bit fl, input bit ps, input logic [31:0] tg);
      stallD    = st;
      flushD    = fl;
      pcSrcE    = ps;
      pcTargetE = tg;
      drive_mem();
      @(posedge clk);
      model_step();
      #1;
      compare();
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      model_reset();
      mem_busy = 0;
      #1;
      check32("rst_instrD", instrD, 32'h0000_0013);
      check32("rst_pcD", pcD, 32'h0);
      check32("rst_pcPlus4D", pcPlus4D, 32'h0);
      check1("rst_validD", validD, 1'b0);
      check1("rst_imemReq", imemReq, 1'b0);
      cycle(0, 0, 0, 32'h0);
      cycle(0, 0, 0, 32'h0);
      reset    = 1'b0;
      imemAck  = 1'b0;
      mem_busy = 0;
   endtask

   task automatic wait_valid(input string name);
      int k;
      k = 0;
      do begin
         cycle(0, 0, 0, 32'h0);
         k++;
      end while (!validD && k < 20);
      check1(name, validD, 1'b1);
   endtask

   initial begin
      n_tests   = 0;
      n_fail    = 0;
      lat_mode  = 0;
      mem_left  = 0;
      mem_busy  = 0;
      reset     = 1'b0;
      stallD    = 1'b0;
      flushD    = 1'b0;
      pcSrcE    = 1'b0;
      pcTargetE = 32'h0;
      imemAck   = 1'b0;
      imemRdata = 32'h0;
      model_reset();
      #2;
      apply_reset();

      // zero-wait memory: one instruction per cycle
      lat_mode = 0;
      cycle(0, 0, 0, 32'h0);
      check1("A_req_rise", imemReq, 1'b1);
      check32("A_addr_reset_pc", imemAddr, 32'h0);
      for (int i = 0; i < 4; i++) begin
         cycle(0, 0, 0, 32'h0);
         check32("A_pcD_seq", pcD, 32'(i * 4));
         check1("A_valid_seq", validD, 1'b1);
      end

      // stall while the response for 0x8 arrives
      apply_reset();
      cycle(0, 0, 0, 32'h0);
      cycle(0, 0, 0, 32'h0);
      cycle(0, 0, 0, 32'h0);
      check32("B_pcD_4", pcD, 32'h4);
      check32("B_addr_8", imemAddr, 32'h8);
      for (int i = 0; i < 3; i++) begin
         cycle(1, 0, 0, 32'h0);
         check32("B_hold_pcD", pcD, 32'h4);
         check1("B_hold_noreq", imemReq, 1'b0);
      end
      cycle(0, 0, 0, 32'h0);
      check32("B_release_pcD", pcD, 32'h8);
      check32("B_release_instr", instrD, memf(32'h8));

      // two wait states, then redirect while 0x10 is pending
      lat_mode = 2;
      cycle(0, 0, 0, 32'h0);
      check1("C_bubble1_valid", validD, 1'b0);
      check32("C_bubble1_instr", instrD, 32'h0000_0013);
      cycle(0, 0, 0, 32'h0);
      check1("C_bubble2_valid", validD, 1'b0);
      check32("C_addr_stable", imemAddr, 32'hC);
      cycle(0, 0, 0, 32'h0);
      check1("C_valid_C", validD, 1'b1);
      check32("C_pcD_C", pcD, 32'hC);
      cycle(0, 0, 0, 32'h0);
      check32("C_addr_10", imemAddr, 32'h10);
      cycle(0, 0, 1, 32'h100);
      check32("C_drop_addr_held", imemAddr, 32'h10);
      wait_valid("C_wait_valid");
      check32("C_redirect_pcD", pcD, 32'h100);
      check32("C_redirect_instr", instrD, memf(32'h100));

      // redirect and flush together with an ack
      lat_mode = 0;
      cycle(0, 1, 1, 32'h200);
      check1("D_flush_valid", validD, 1'b0);
      check32("D_next_addr", imemAddr, 32'h200);
      cycle(0, 0, 0, 32'h0);
      check32("D_pcD_200", pcD, 32'h200);

      // reset in the middle of a wait, then fetch across the top of memory
      lat_mode = 3;
      cycle(0, 0, 0, 32'h0);
      cycle(0, 0, 0, 32'h0);
      apply_reset();
      lat_mode = 0;
      cycle(0, 0, 0, 32'h0);
      check1("E_req_rise", imemReq, 1'b1);
      check32("E_addr_reset_pc", imemAddr, 32'h0);
      cycle(0, 1, 1, 32'hFFFF_FFFF);
      check32("E_addr_top", imemAddr, 32'hFFFF_FFFC);
      cycle(0, 0, 0, 32'h0);
      check32("E_pcD_top", pcD, 32'hFFFF_FFFC);
      check32("E_pcPlus4_wrap", pcPlus4D, 32'h0);
      check32("E_addr_wrap", imemAddr, 32'h0);

      // randomized pipeline controls and memory latency
      lat_mode = -1;
      for (int i = 0; i < 1500; i++) begin
         bit st, fl, ps;
         if ($urandom_range(0, 299) == 0)
            apply_reset();
         st = ($urandom_range(0, 99) < 25);
         ps = ($urandom_range(0, 99) < 8);
         fl = ps ? ($urandom_range(0, 99) < 70) : ($urandom_range(0, 99) < 8);
         cycle(st, fl, ps, $urandom);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
